// File: rtl/breathe_pkg.sv
// Shared types and default constants for the breathing-LED speed front end.
package breathe_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PRESSED  = 2'd1,
      ST_WAIT_REL = 2'd2
   } press_state_t;

   localparam int unsigned SPEED_W = 2;

   localparam int unsigned DEF_DEB_CYCLES  = 250000;
   localparam int unsigned DEF_LONG_CYCLES = 50000000;

   localparam int unsigned DEF_DIV0 = 10000;
   localparam int unsigned DEF_DIV1 = 5000;
   localparam int unsigned DEF_DIV2 = 2500;
   localparam int unsigned DEF_DIV3 = 1250;

   // Speed index advances modulo 4 (3 wraps to 0).
   function automatic logic [SPEED_W-1:0] next_speed(input logic [SPEED_W-1:0] s);
      return s + SPEED_W'(1);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for an active-low button.
module btn_debounce
   import breathe_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int unsigned CNT_W      = 26
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic btn_db,
   output logic fall_pulse,
   output logic rise_pulse
);

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] deb_cnt;

   // Bring the asynchronous button into the clock domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
      end
   end

   // Accept a new level only after it has differed for DEB_CYCLES cycles; edge pulses
   // are high in the first cycle the new debounced level is visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_db     <= 1'b1;
         deb_cnt    <= '0;
         fall_pulse <= 1'b0;
         rise_pulse <= 1'b0;
      end else begin
         fall_pulse <= 1'b0;
         rise_pulse <= 1'b0;
         if (sync2 == btn_db) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            btn_db     <= sync2;
            deb_cnt    <= '0;
            fall_pulse <= ~sync2;
            rise_pulse <= sync2;
         end else begin
            deb_cnt <= deb_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/breathe_speed_ctrl.sv
// Button front end for the breathing-LED generator: short press cycles the speed,
// long press toggles pause, and a divider produces the step-enable tick.
module breathe_speed_ctrl
   import breathe_pkg::*;
#(
   parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
   parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES,
   parameter int unsigned DIV0        = DEF_DIV0,
   parameter int unsigned DIV1        = DEF_DIV1,
   parameter int unsigned DIV2        = DEF_DIV2,
   parameter int unsigned DIV3        = DEF_DIV3,
   parameter int unsigned CNT_W       = 26
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               btn_n,
   output logic               tick,
   output logic [SPEED_W-1:0] speed_sel,
   output logic               paused,
   output logic               speed_ctrl,
   output logic               long_evt
);

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] D0_LAST   = CNT_W'(DIV0 - 1);
   localparam logic [CNT_W-1:0] D1_LAST   = CNT_W'(DIV1 - 1);
   localparam logic [CNT_W-1:0] D2_LAST   = CNT_W'(DIV2 - 1);
   localparam logic [CNT_W-1:0] D3_LAST   = CNT_W'(DIV3 - 1);

   logic               btn_db;
   logic               fall_pulse;
   logic               rise_pulse;

   press_state_t       state;
   press_state_t       state_nxt;
   logic [CNT_W-1:0]   hold_cnt;
   logic [CNT_W-1:0]   hold_nxt;
   logic [SPEED_W-1:0] speed_nxt;
   logic               paused_nxt;
   logic               long_nxt;
   logic               speed_inc;

   logic [CNT_W-1:0]   div_cnt;
   logic [CNT_W-1:0]   div_last;

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
   ) u_debounce (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_n      (btn_n),
      .btn_db     (btn_db),
      .fall_pulse (fall_pulse),
      .rise_pulse (rise_pulse)
   );

   // Press FSM state and its registered actions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         hold_cnt  <= '0;
         speed_sel <= '0;
         paused    <= 1'b0;
         long_evt  <= 1'b0;
      end else begin
         state     <= state_nxt;
         hold_cnt  <= hold_nxt;
         speed_sel <= speed_nxt;
         paused    <= paused_nxt;
         long_evt  <= long_nxt;
      end
   end

   // Next-state logic; the long threshold is checked before release so a release
   // landing on the threshold cycle still counts as long.
   always_comb begin
      state_nxt  = state;
      hold_nxt   = hold_cnt;
      speed_nxt  = speed_sel;
      paused_nxt = paused;
      long_nxt   = 1'b0;
      speed_inc  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (fall_pulse) begin
               state_nxt = ST_PRESSED;
               hold_nxt  = '0;
            end
         end
         ST_PRESSED: begin
            if (hold_cnt == LONG_LAST) begin
               paused_nxt = ~paused;
               long_nxt   = 1'b1;
               state_nxt  = ST_WAIT_REL;
            end else if (rise_pulse) begin
               speed_inc = 1'b1;
               speed_nxt = next_speed(speed_sel);
               state_nxt = ST_IDLE;
            end else begin
               hold_nxt = hold_cnt + CNT_W'(1);
            end
         end
         ST_WAIT_REL: begin
            if (btn_db) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Terminal count for the selected speed.
   always_comb begin
      div_last = D0_LAST;
      case (speed_sel)
         2'd0:    div_last = D0_LAST;
         2'd1:    div_last = D1_LAST;
         2'd2:    div_last = D2_LAST;
         default: div_last = D3_LAST;
      endcase
   end

   // Tick divider; frozen at zero while paused and restarted on a speed change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else if (paused || speed_inc) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else if (div_cnt == div_last) begin
         div_cnt <= '0;
         tick    <= 1'b1;
      end else begin
         div_cnt <= div_cnt + CNT_W'(1);
         tick    <= 1'b0;
      end
   end

   assign speed_ctrl = speed_sel[1];

endmodule
